// File: rtl/reduce_stream.sv
// Packet-wise bitwise reduction (AND/OR/XOR) over a multi-word input stream,
// one result per packet. Optional beat counter output when REDUCE_STREAM_BEATS_EN is defined.
module reduce_stream #(
    parameter int PORT_NUM = 2,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PORT_NUM*WIDTH-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          q,
    output logic                      q_all
`ifdef REDUCE_STREAM_BEATS_EN
    ,
    output logic [15:0]               beats
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    state_t             state, state_next;
    logic [1:0]         op_r;
    logic [1:0]         op_cur;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic               accept;
    logic               first_beat;

    function automatic logic [1:0] norm_op(input logic [1:0] m);
        return (m == 2'b11) ? OP_AND : m;
    endfunction

    function automatic logic [WIDTH-1:0] identity(input logic [1:0] op);
        return (op == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic reduce_bits(input logic [1:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_OR:   return |v;
            OP_XOR:  return ^v;
            default: return &v;
        endcase
    endfunction

    assign in_ready   = (state != HOLD) || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == HOLD);
    // A beat taken outside ACCUM always opens a new packet, including the HOLD hand-over case.
    assign first_beat = (state != ACCUM);
    assign op_cur     = first_beat ? norm_op(mode) : op_r;

    always_comb begin
        acc_next = first_beat ? identity(op_cur) : acc;
        for (int k = 0; k < PORT_NUM; k++) begin
            acc_next = combine(op_cur, acc_next, in_data[k*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = in_last ? HOLD : ACCUM;
        end else if ((state == HOLD) && out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            op_r  <= OP_AND;
            q     <= '0;
            q_all <= 1'b0;
        end else if (accept) begin
            op_r <= op_cur;
            if (in_last) begin
                q     <= acc_next;
                q_all <= reduce_bits(op_cur, acc_next);
                acc   <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

`ifdef REDUCE_STREAM_BEATS_EN
    logic [15:0] cnt;
    logic [15:0] cnt_next;

    always_comb begin
        if (first_beat) begin
            cnt_next = 16'd1;
        end else if (cnt == 16'hFFFF) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            beats <= '0;
        end else if (accept) begin
            if (in_last) begin
                beats <= cnt_next;
                cnt   <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reduce_stream.sv
// Bench for reduce_stream (PORT_NUM=2, WIDTH=7): directed cases plus random traffic
// against a packet-level reference model.
module tb_reduce_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  q;
    logic        q_all;
`ifdef REDUCE_STREAM_BEATS_EN
    logic [15:0] beats;
`endif

    always #5 clk = ~clk;

    reduce_stream #(.PORT_NUM(2), .WIDTH(7)) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q(q),
        .q_all(q_all)
`ifdef REDUCE_STREAM_BEATS_EN
        ,
        .beats(beats)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a packet is a list of words; its result is the fold of that list.
    bit          pending;
    bit          in_pkt;
    logic [6:0]  exp_q;
    logic        exp_qall;
    logic [15:0] exp_beats;
    logic [15:0] pkt_beats;
    logic [1:0]  pkt_mode;
    logic [6:0]  pkt_words[$];

    function automatic logic [6:0] fold(input logic [1:0] m);
        logic [6:0] r;
        r = (m == 2'b01 || m == 2'b10) ? 7'h00 : 7'h7F;
        foreach (pkt_words[i]) begin
            if (m == 2'b01)      r = r | pkt_words[i];
            else if (m == 2'b10) r = r ^ pkt_words[i];
            else                 r = r & pkt_words[i];
        end
        return r;
    endfunction

    function automatic logic all_bits(input logic [1:0] m, input logic [6:0] v);
        int ones;
        ones = $countones(v);
        if (m == 2'b01) return ones != 0;
        if (m == 2'b10) return ones % 2 == 1;
        return ones == 7;
    endfunction

    task automatic model_edge();
        bit take;
        if (reset) begin
            pending   = 0;
            in_pkt    = 0;
            exp_q     = '0;
            exp_qall  = 1'b0;
            exp_beats = '0;
            pkt_words.delete();
        end else begin
            take = in_valid && (!pending || out_ready);
            if (pending && out_ready) pending = 0;
            if (take) begin
                if (!in_pkt) begin
                    in_pkt    = 1;
                    pkt_mode  = mode;
                    pkt_beats = '0;
                    pkt_words.delete();
                end
                pkt_words.push_back(in_data[6:0]);
                pkt_words.push_back(in_data[13:7]);
                if (pkt_beats != 16'hFFFF) pkt_beats++;
                if (in_last) begin
                    exp_q     = fold(pkt_mode);
                    exp_qall  = all_bits(pkt_mode, exp_q);
                    exp_beats = pkt_beats;
                    pending   = 1;
                    in_pkt    = 0;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [13:0] d,
                        input logic l, input logic r);
        in_valid  = v;
        mode      = m;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(!pending || out_ready));
            check("out_valid", 32'(out_valid), 32'(pending));
            if (pending) begin
                check("q", 32'(q), 32'(exp_q));
                check("q_all", 32'(q_all), 32'(exp_qall));
`ifdef REDUCE_STREAM_BEATS_EN
                check("beats", 32'(beats), 32'(exp_beats));
`endif
            end
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_q_all", 32'(q_all), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef REDUCE_STREAM_BEATS_EN
        check("rst_beats", 32'(beats), 32'd0);
`endif

        // single-beat AND packet
        step(1'b1, 2'b00, {7'h7F, 7'h7F}, 1'b1, 1'b1);
        check("and1_valid", 32'(out_valid), 32'd1);
        check("and1_q", 32'(q), 32'h7F);
        check("and1_q_all", 32'(q_all), 32'd1);
        step(1'b0, 2'b00, '0, 1'b0, 1'b1);

        // OR packet, mode change on second beat ignored
        step(1'b1, 2'b01, {7'h01, 7'h02}, 1'b0, 1'b1);
        step(1'b1, 2'b00, {7'h04, 7'h00}, 1'b1, 1'b1);
        check("or_q", 32'(q), 32'h07);
        check("or_q_all", 32'(q_all), 32'd1);
        step(1'b0, 2'b00, '0, 1'b0, 1'b1);

        // XOR packet, then held while the consumer stalls
        step(1'b1, 2'b10, {7'h55, 7'h2A}, 1'b0, 1'b1);
        step(1'b1, 2'b10, {7'h7F, 7'h00}, 1'b1, 1'b0);
        check("xor_q", 32'(q), 32'h00);
        check("xor_q_all", 32'(q_all), 32'd0);
`ifdef REDUCE_STREAM_BEATS_EN
        check("xor_beats", 32'(beats), 32'd2);
`endif
        repeat (3) step(1'b1, 2'b01, {7'h11, 7'h22}, 1'b1, 1'b0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_q", 32'(q), 32'h00);
        step(1'b1, 2'b01, {7'h11, 7'h22}, 1'b1, 1'b1);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_q", 32'(q), 32'h33);
        check("b2b_q_all", 32'(q_all), 32'd1);
        step(1'b0, 2'b00, '0, 1'b0, 1'b1);

        // reset in the middle of a packet
        step(1'b1, 2'b00, {7'h7F, 7'h7F}, 1'b0, 1'b1);
        reset = 1'b1;
        step(1'b1, 2'b00, {7'h7F, 7'h7F}, 1'b1, 1'b1);
        reset = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_q", 32'(q), 32'd0);
        step(1'b1, 2'b00, {7'h0F, 7'h3C}, 1'b1, 1'b1);
        check("after_rst_q", 32'(q), 32'h0C);
        check("after_rst_q_all", 32'(q_all), 32'd0);
        step(1'b0, 2'b00, '0, 1'b0, 1'b1);

        // random traffic, including mode 11 and occasional resets
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) == 0);
            step(1'($urandom), 2'($urandom), 14'($urandom), ($urandom_range(2) == 0),
                 ($urandom_range(3) != 0));
            reset = 1'b0;
        end
        repeat (2) step(1'b0, 2'b00, '0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reduce_stream.md
REDUCE_STREAM -- requirements
Module: reduce_stream

Interface
REQ-001 SHALL have parameter PORT_NUM, default 2: number of WIDTH-bit words carried per input beat (>=1).
REQ-002 SHALL have parameter WIDTH, default 8: word width in bits (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mode  input  2  reduction op: 00 AND, 01 OR, 10 XOR, 11 treated as AND.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat.
REQ-008 SHALL have port in_data  input  PORT_NUM*WIDTH  word k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_last  input  1  beat is final beat of packet.
REQ-010 SHALL have port out_valid  output  1  packet result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port q  output  WIDTH  bitwise reduction of every word of the packet.
REQ-013 SHALL have port q_all  output  1  same op applied across the WIDTH bits of q.

Function
REQ-014 SHALL accept a beat when in_valid && in_ready on a rising edge; no other beat affects state.
REQ-015 SHALL implement states IDLE (no partial packet), ACCUM (partial packet held), HOLD (result pending, out_valid=1).
REQ-016 SHALL sample mode on the first beat of a packet and use it for the whole packet; mode changes mid-packet ignored.
REQ-017 SHALL seed the accumulator with the op identity (AND: all ones; OR/XOR: zero) before combining the first beat.
REQ-018 SHALL combine all PORT_NUM words of each accepted beat into the accumulator in the same cycle.
REQ-019 Transitions: IDLE->ACCUM on accepted non-last beat; IDLE/ACCUM->HOLD on accepted last beat; ACCUM stays ACCUM on non-last beat.
REQ-020 SHALL assert out_valid exactly one cycle after the last beat is accepted (latency 1), with q/q_all valid same cycle.
REQ-021 SHALL hold q, q_all, out_valid stable while out_valid && !out_ready.
REQ-022 HOLD->IDLE on out_ready with no accepted beat; HOLD->HOLD (new single-beat result) or HOLD->ACCUM when a beat is accepted in the same cycle the result is consumed.
REQ-023 in_ready SHALL equal (state != HOLD) || out_ready, combinationally.
REQ-024 A single-beat packet (in_last on first beat) SHALL yield the reduction of that beat's words only.
REQ-025 q_all SHALL equal &q, |q, or ^q per the packet's sampled mode.

Reset
REQ-026 On reset high at a clock edge: state IDLE, out_valid=0, q=0, q_all=0, accumulator cleared; any partial packet or pending result discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts; reset SHALL override any simultaneous beat or out_ready.

Configuration
REQ-028 With macro REDUCE_STREAM_BEATS_EN defined, SHALL add port beats  output  16  number of beats in the reported packet, saturating at 16'hFFFF, valid with out_valid, reset to 0.
REQ-029 Without REDUCE_STREAM_BEATS_EN, port beats and its counter SHALL not exist; all other behaviour identical.

Verification (PORT_NUM=2, WIDTH=7)
REQ-030 Reset, then mode=00, one beat {7'h7F,7'h7F} with in_last, out_ready=1 -> next cycle out_valid=1, q=7'h7F, q_all=1.
REQ-031 mode=01, beats {7'h01,7'h02},{7'h04,7'h00} (last on 2nd); mode set to 00 at 2nd beat -> q=7'h07, q_all=1 (OR kept).
REQ-032 mode=10, beats {7'h55,7'h2A},{7'h7F,7'h00} last -> q=7'h00, q_all=0; with BEATS_EN, beats=2.
REQ-033 Result pending with out_ready=0 for 3 cycles -> q stable, in_ready=0, in_valid beats not accepted; out_ready=1 plus new last beat -> next result in following cycle, no bubble.
REQ-034 Reset asserted mid-packet after 1 of 3 beats -> out_valid=0, q=0; next packet {7'h0F,7'h3C} last, mode=00 -> q=7'h0C, q_all=0.
